// File: rtl/xor_pkg.sv
// Shared types and helpers for the XOR checksum datapath.
// Holds the frame FSM encoding and the beat-counter width derivation.
package xor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Counter must represent 0..max_len inclusive.
   function automatic int len_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/xor_reduce.sv
// Reduction-XOR tree over a WIDTH-bit word, purely combinational (0 cycles).
// No flow control; the caller qualifies the result.
module xor_reduce #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data,
   output logic             parity
);

   assign parity = ^data;

endmodule

// File: rtl/xor_checksum.sv
// Framed XOR accumulator: checksum/parity/count/overflow valid the cycle after the closing beat.
// in_ready drops while a result is held; the result holds until out_ready, then one idle cycle.
module xor_checksum
   import xor_pkg::*;
#(
   parameter  int WIDTH   = 8,
   parameter  int MAX_LEN = 16,
   localparam int LEN_W   = len_width(MAX_LEN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_checksum,
   output logic             out_parity,
   output logic [LEN_W-1:0] out_count,
   output logic             out_overflow
);

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [LEN_W-1:0] cnt;

   logic             accept;
   logic             close;
   logic [WIDTH-1:0] sum_nxt;
   logic [LEN_W-1:0] cnt_nxt;
   logic             parity_nxt;

   // Gating with rst_n keeps upstream from believing a beat was taken during reset.
   assign in_ready = rst_n && (state != HOLD);
   assign accept   = in_valid && in_ready;
   assign sum_nxt  = (state == IDLE) ? in_data : (acc ^ in_data);
   assign cnt_nxt  = cnt + LEN_W'(1);
   assign close    = accept && (in_last || (cnt_nxt == LEN_W'(MAX_LEN)));

   xor_reduce #(.WIDTH(WIDTH)) u_parity (
      .data   (sum_nxt),
      .parity (parity_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         acc          <= '0;
         cnt          <= '0;
         out_valid    <= 1'b0;
         out_checksum <= '0;
         out_parity   <= 1'b0;
         out_count    <= '0;
         out_overflow <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc <= sum_nxt;
                  cnt <= cnt_nxt;
                  if (close) begin
                     state        <= HOLD;
                     out_valid    <= 1'b1;
                     out_checksum <= sum_nxt;
                     out_parity   <= parity_nxt;
                     out_count    <= cnt_nxt;
                     out_overflow <= ~in_last;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  acc       <= '0;
                  cnt       <= '0;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xor_checksum.sv
// Bench for xor_checksum: directed frames with literal results, then randomized
// frames against a queue-based frame model compared every cycle.
module tb_xor_checksum;

   localparam int WIDTH   = 8;
   localparam int MAX_LEN = 16;
   localparam int LW      = $clog2(MAX_LEN + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_checksum;
   logic             out_parity;
   logic [LW-1:0]    out_count;
   logic             out_overflow;

   int tests = 0;
   int fails = 0;
   bit checking  = 1'b0;
   bit rand_ordy = 1'b0;

   // Frame model: words of the open frame plus the last produced result.
   int         frame_q[$];
   bit         m_valid;
   int         m_cs, m_par, m_cnt, m_ovf;

   xor_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_checksum (out_checksum),
      .out_parity   (out_parity),
      .out_count    (out_count),
      .out_overflow (out_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: advance on each clock edge from the inputs presented before it.
   initial begin
      m_valid = 0; m_cs = 0; m_par = 0; m_cnt = 0; m_ovf = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            frame_q.delete();
            m_valid = 0; m_cs = 0; m_par = 0; m_cnt = 0; m_ovf = 0;
         end else if (m_valid) begin
            if (out_ready) m_valid = 0;
         end else if (in_valid) begin
            frame_q.push_back(int'(in_data));
            if (in_last || frame_q.size() == MAX_LEN) begin
               m_cs = 0;
               foreach (frame_q[i]) m_cs = m_cs ^ frame_q[i];
               m_cnt   = frame_q.size();
               m_ovf   = in_last ? 0 : 1;
               m_par   = $countones(m_cs) % 2;
               m_valid = 1;
               frame_q.delete();
            end
         end
      end
   end

   // Cycle compare against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (checking) begin
            check("in_ready",     32'(in_ready),     32'((rst_n && !m_valid) ? 1 : 0));
            check("out_valid",    32'(out_valid),    32'(m_valid));
            check("out_checksum", 32'(out_checksum), 32'(m_cs));
            check("out_parity",   32'(out_parity),   32'(m_par));
            check("out_count",    32'(out_count),    32'(m_cnt));
            check("out_overflow", 32'(out_overflow), 32'(m_ovf));
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ordy) out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         in_data = WIDTH'($urandom);
         in_last = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
   endtask

   // Called and returns at posedge+1; holds the beat until the handshake.
   task automatic send(input logic [WIDTH-1:0] d, input logic l);
      logic rdy;
      int   guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      forever begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (rdy) break;
         guard++;
         if (guard > 200) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: beat %0h not accepted within 200 cycles", d);
            break;
         end
      end
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
      in_last  = 1'($urandom_range(0, 1));
   endtask

   // Expects out_valid within `budget` cycles, checks literals, returns at posedge+1.
   task automatic wait_result(input string name, input int budget, input int cs,
                              input int par, input int cnt, input int ovf);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1;
            break;
         end
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL %s_latency: out_valid not seen within %0d cycles", name, budget);
      end else begin
         check({name, "_cs"},    32'(out_checksum), 32'(cs));
         check({name, "_par"},   32'(out_parity),   32'(par));
         check({name, "_cnt"},   32'(out_count),    32'(cnt));
         check({name, "_ovf"},   32'(out_overflow), 32'(ovf));
         check({name, "_hold"},  32'(in_ready),     32'd0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int len;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      @(posedge clk);
      checking = 1'b1;
      @(negedge clk);
      check("reset_in_ready",  32'(in_ready),     32'd0);
      check("reset_out_valid", 32'(out_valid),    32'd0);
      check("reset_cs",        32'(out_checksum), 32'd0);
      check("reset_count",     32'(out_count),    32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Basic three-beat frame, immediate consume, one idle cycle.
      send(8'h0F, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h3C, 1'b1);
      wait_result("basic", 1, 'hC3, 0, 3, 0);
      @(negedge clk);
      check("basic_ready_back", 32'(in_ready),  32'd1);
      check("basic_valid_drop", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;

      // Single-beat frames from IDLE.
      send(8'hA5, 1'b1);
      wait_result("single_a5", 1, 'hA5, 0, 1, 0);
      send(8'h01, 1'b1);
      wait_result("single_01", 1, 'h01, 1, 1, 0);

      // Backpressure: result held stable for five cycles.
      out_ready = 1'b0;
      send(8'h12, 1'b0);
      send(8'h34, 1'b1);
      wait_result("bp", 1, 'h26, 1, 2, 0);
      repeat (4) begin
         @(negedge clk);
         check("bp_valid", 32'(out_valid),    32'd1);
         check("bp_cs",    32'(out_checksum), 32'h26);
         check("bp_ready", 32'(in_ready),     32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_release", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;

      // Forced close at MAX_LEN, then a fresh one-beat frame.
      out_ready = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) send(8'h01, 1'b0);
      wait_result("ovf", 1, 'h00, 0, MAX_LEN, 1);
      out_ready = 1'b1;
      send(8'h77, 1'b1);
      wait_result("after_ovf", 1, 'h77, 0, 1, 0);

      // Reset mid-frame discards the partial frame.
      send(8'hFF, 1'b0);
      send(8'hAA, 1'b0);
      @(negedge clk);
      check("pre_rst_no_out", 32'(out_valid), 32'd0);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_in_ready", 32'(in_ready),     32'd0);
      check("midrst_cs",       32'(out_checksum), 32'd0);
      check("midrst_par",      32'(out_parity),   32'd0);
      check("midrst_ovf",      32'(out_overflow), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(8'h55, 1'b1);
      wait_result("post_rst", 1, 'h55, 0, 1, 0);

      // Bubbles between beats do not disturb accumulation.
      send(8'h80, 1'b0);
      idle(2);
      send(8'h01, 1'b0);
      idle(2);
      send(8'h02, 1'b1);
      wait_result("bubbles", 1, 'h83, 1, 3, 0);

      // Randomized frames, some longer than MAX_LEN, random gaps and backpressure.
      rand_ordy = 1'b1;
      repeat (40) begin
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) begin
            send(WIDTH'($urandom), (i == len - 1) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         end
      end
      rand_ordy = 1'b0;
      out_ready = 1'b1;
      idle(5);

      checking = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
